// File: rtl/mips_pkg.sv
// Shared loader types and widths: word/byte geometry and the loader FSM state encoding.
package mips_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        LOAD  = 3'd1,
        CSUM  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    // Program-memory capacity in words for a given word-address width.
    function automatic logic [WORD_W-1:0] capacity_words(input int addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Byte-stream input and program-memory write port of the loader, bundled as one interface.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic                          in_valid;
    logic [mips_pkg::BYTE_W-1:0]   in_data;
    logic                          in_ready;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [mips_pkg::WORD_W-1:0]   mem_wdata;

    // Byte source / memory side.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_mem_loader_byte_packer.sv
// Collects accepted bytes big-endian into 32-bit words; word_valid pulses with the 4th byte.
module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    localparam int              CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]         byte_cnt_reg;
    logic [WORD_W-BYTE_W-1:0] shift_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
        end else if (byte_valid) begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            shift_reg    <= {shift_reg[WORD_W-2*BYTE_W-1:0], byte_data};
        end
    end

    // The final byte is merged combinationally so the word is usable on its accepting edge.
    assign word       = {shift_reg, byte_data};
    assign word_valid = byte_valid && (byte_cnt_reg == LAST);

endmodule

// File: rtl/prog_mem_loader.sv
// Program-memory loader: header word N, then N words written to addresses 0..N-1; releases cpu_reset when done.
// Define LOADER_CHECKSUM_EN to require a trailing word equal to the mod-2**32 sum of the data words.
module prog_mem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    prog_mem_loader_if.slave bus,
    output logic             cpu_reset,
    output logic             done,
    output logic             error
);
    localparam logic [2:0] S_HDR   = HDR;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_DONE  = DONE;
    localparam logic [2:0] S_ERROR = ERROR;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = CSUM;
    localparam logic [2:0] S_TAIL  = S_CSUM;
`else
    localparam logic [2:0] S_TAIL  = S_DONE;
`endif
    localparam logic [WORD_W-1:0] CAPACITY = capacity_words(ADDR_W);

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W:0]   word_cnt_reg, word_cnt_next;
    logic [ADDR_W:0]   n_reg, n_next;
    logic              in_ready_reg, in_ready_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              cpu_reset_reg, cpu_reset_next;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_reg, sum_next;
`endif

    logic              accept;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign accept = bus.in_valid && in_ready_reg;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (accept),
        .byte_data  (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next     = state_reg;
        word_cnt_next  = word_cnt_reg;
        n_next         = n_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
`ifdef LOADER_CHECKSUM_EN
        sum_next       = sum_reg;
`endif
        case (state_reg)
            S_HDR: begin
                if (word_valid) begin
                    if (word > CAPACITY) begin
                        state_next = S_ERROR;
                    end else if (word == '0) begin
                        state_next = S_TAIL;
                    end else begin
                        n_next     = word[ADDR_W:0];
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = word_cnt_reg[ADDR_W-1:0];
                    mem_wdata_next = word;
                    word_cnt_next  = word_cnt_reg + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_next       = sum_reg + word;
`endif
                    if (word_cnt_next == n_reg) begin
                        state_next = S_TAIL;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_valid) begin
                    state_next = (word == sum_reg) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: begin
            end
        endcase

        // in_ready tracks the state being entered so it is never high in DONE/ERROR.
        case (state_next)
            S_HDR, S_LOAD: in_ready_next = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:        in_ready_next = 1'b1;
`endif
            default:       in_ready_next = 1'b0;
        endcase

        // Released one cycle after DONE entry, i.e. after the last write pulse.
        cpu_reset_next = cpu_reset_reg && (state_reg != S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_HDR;
            word_cnt_reg  <= '0;
            n_reg         <= '0;
            in_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_reset_reg <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            word_cnt_reg  <= word_cnt_next;
            n_reg         <= n_next;
            in_ready_reg  <= in_ready_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            cpu_reset_reg <= cpu_reset_next;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= sum_next;
`endif
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign cpu_reset     = cpu_reset_reg;
    assign done          = (state_reg == S_DONE);
    assign error         = (state_reg == S_ERROR);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized bench for prog_mem_loader: framed byte streams checked against a stream-level reference model.
module tb_prog_mem_loader;
    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    typedef logic [7:0]  byte_q_t [$];
    typedef logic [31:0] word_q_t [$];

    logic clk;
    logic reset;
    logic cpu_reset;
    logic done;
    logic error;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    int                release_q [$];
    logic              prev_cpu_reset = 1'b1;

    prog_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every write pulse and the write count at which cpu_reset falls.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (prev_cpu_reset && cpu_reset === 1'b0) begin
            release_q.push_back(wr_addr_q.size());
        end
        prev_cpu_reset <= cpu_reset;
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic byte_q_t word_bytes(input logic [31:0] w);
        byte_q_t r;
        r.push_back(w[31:24]);
        r.push_back(w[23:16]);
        r.push_back(w[15:8]);
        r.push_back(w[7:0]);
        return r;
    endfunction

    function automatic byte_q_t raw_stream(input logic [31:0] n, input word_q_t words);
        byte_q_t q;
        q = word_bytes(n);
        foreach (words[i]) q = {q, word_bytes(words[i])};
        return q;
    endfunction

    // Header + words, plus the trailing sum word when the checksum build is in use.
    function automatic byte_q_t framed_stream(input logic [31:0] n, input word_q_t words);
        byte_q_t q;
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] s;
        s = '0;
        foreach (words[i]) s = s + words[i];
        q = {raw_stream(n, words), word_bytes(s)};
`else
        q = raw_stream(n, words);
`endif
        return q;
    endfunction

    function automatic word_q_t random_words(input int n);
        word_q_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_value({tag, "_in_ready"},  bus.in_ready,  0);
        check_value({tag, "_mem_we"},    bus.mem_we,    0);
        check_value({tag, "_mem_addr"},  bus.mem_addr,  0);
        check_value({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check_value({tag, "_cpu_reset"}, cpu_reset,     1);
        check_value({tag, "_done"},      done,          0);
        check_value({tag, "_error"},     error,         0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Offer each byte with random idle cycles; a byte is taken on the posedge following a negedge with in_ready high.
    task automatic send_bytes(input byte_q_t q, input int idle_pct);
        int waited;
        foreach (q[i]) begin
            @(negedge clk);
            while ($urandom_range(99) < idle_pct) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = q[i];
            waited = 0;
            while (bus.in_ready !== 1'b1 && waited < 50) begin
                waited++;
                @(negedge clk);
            end
            if (bus.in_ready !== 1'b1) begin
                check_value("in_ready_timeout", bus.in_ready, 1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_stream(input string tag, input byte_q_t q, input int idle_pct, input bit fast_done);
        word_q_t     exp_w;
        logic [31:0] n;
        logic [31:0] sum;
        bit          exp_done;
        int          base_w, base_r, got_w, n_cmp, base2;
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] c;
`endif
        apply_reset();
        base_w = wr_addr_q.size();
        base_r = release_q.size();

        // Reference: parse the byte list directly into the expected memory image and outcome.
        n        = {q[0], q[1], q[2], q[3]};
        sum      = '0;
        exp_done = 1'b0;
        if (n <= CAP) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_w.push_back({q[4+4*i], q[5+4*i], q[6+4*i], q[7+4*i]});
                sum = sum + exp_w[i];
            end
`ifdef LOADER_CHECKSUM_EN
            c = {q[4+4*int'(n)], q[5+4*int'(n)], q[6+4*int'(n)], q[7+4*int'(n)]};
            exp_done = (c == sum);
`else
            exp_done = 1'b1;
`endif
        end

        send_bytes(q, idle_pct);
        if (fast_done) begin
            check_value({tag, "_fast_done"},     done,         1);
            check_value({tag, "_fast_in_ready"}, bus.in_ready, 0);
        end
        repeat (4) @(negedge clk);

        got_w = wr_addr_q.size() - base_w;
        check_value({tag, "_wcount"}, got_w, exp_w.size());
        n_cmp = (got_w < exp_w.size()) ? got_w : exp_w.size();
        for (int i = 0; i < n_cmp; i++) begin
            check_value($sformatf("%s_addr%0d", tag, i), wr_addr_q[base_w+i], i);
            check_value($sformatf("%s_data%0d", tag, i), wr_data_q[base_w+i], exp_w[i]);
        end
        check_value({tag, "_done"},      done,          exp_done);
        check_value({tag, "_error"},     error,         !exp_done);
        check_value({tag, "_cpu_reset"}, cpu_reset,     !exp_done);
        check_value({tag, "_in_ready"},  bus.in_ready,  0);
        check_value({tag, "_releases"},  release_q.size() - base_r, exp_done ? 1 : 0);
        if (exp_done && release_q.size() > base_r)
            check_value({tag, "_release_after"}, release_q[base_r] - base_w, exp_w.size());

        // Bytes offered after completion must be ignored.
        base2 = wr_addr_q.size();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        check_value({tag, "_late_in_ready"}, bus.in_ready, 0);
        check_value({tag, "_late_writes"},   wr_addr_q.size() - base2, 0);
        check_value({tag, "_late_done"},     done, exp_done);

        $display("stream %s: n=%0d gap=%0d%% writes=%0d done=%0b error=%0b",
                 tag, n, idle_pct, got_w, done, error);
    endtask

    initial begin
        word_q_t wq;
        word_q_t empty;
        byte_q_t bq;
        int      n, base_w;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        wq = {32'h20080005, 32'h20090007};
        run_stream("two_words", framed_stream(2, wq), 0, 1'b0);

        run_stream("zero_len", framed_stream(0, empty), 0, 1'b1);

        run_stream("over_cap", raw_stream(32'h00000101, empty), 0, 1'b0);

        run_stream("full_cap", framed_stream(CAP, random_words(CAP)), 0, 1'b0);

        wq = random_words(16);
        run_stream("w16_nogap", framed_stream(16, wq), 0, 1'b0);
        run_stream("w16_gap30", framed_stream(16, wq), 30, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(24, 1);
            run_stream($sformatf("rand%0d", r), framed_stream(n, random_words(n)),
                       $urandom_range(50, 0), 1'b0);
        end

        // Reset in the middle of a 3-word load, after two words have been written.
        apply_reset();
        base_w = wr_addr_q.size();
        wq = random_words(3);
        bq = raw_stream(3, wq);
        bq = bq[0:11];
        send_bytes(bq, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("midload");
        check_value("midload_writes", wr_addr_q.size() - base_w, 2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_stream("reload", framed_stream(1, random_words(1)), 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        wq = {32'h00000001, 32'hFFFFFFFF};
        bq = {raw_stream(2, wq), word_bytes(32'h00000000)};
        run_stream("csum_ok", bq, 0, 1'b0);
        bq = {raw_stream(2, wq), word_bytes(32'h00000001)};
        run_stream("csum_bad", bq, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
